hazard_controller: RTL and testbench
====================================

HAZARD_CONTROLLER -- requirements
Module: hazard_controller

Interface
REQ-001 SHALL provide parameter STALL_CNT_BITS, default 32, width of the stall/flush performance counters.
REQ-002 SHALL provide parameter DIV_TIMEOUT, default 64, maximum number of DIV_WAIT cycles before the timeout flag is set.
REQ-003 SHALL provide port clk, input, 1 bit: the single clock for the block.
REQ-004 SHALL provide port rst, input, 1 bit: synchronous active-high reset.
REQ-005 SHALL provide inputs hzd_exe_to_id_A, hzd_mem_to_exe_A, hzd_mem_to_exe_B, 1 bit each: load-use hazard flags from the forwarding unit.
REQ-006 SHALL provide input id_jump, 1 bit: a JAL or JALR in ID is redirecting the PC.
REQ-007 SHALL provide input exe_branch_taken, 1 bit: the branch in EXE resolved taken.
REQ-008 SHALL provide inputs exe_div_start and div_done, 1 bit each: a divide/remainder begins in EXE; the divider result is valid.
REQ-009 SHALL provide outputs if_stall, id_stall, exe_stall, mem_stall, 1 bit each: hold the PC and IF/ID, ID/EXE, EXE/MEM registers.
REQ-010 SHALL provide outputs id_flush, exe_flush, mem_flush, wb_flush, 1 bit each: load a bubble into IF/ID, ID/EXE, EXE/MEM, MEM/WB.
REQ-011 SHALL provide output div_timeout, 1 bit: sticky flag, divider exceeded DIV_TIMEOUT cycles.
REQ-012 SHALL provide outputs stall_count and flush_count, STALL_CNT_BITS bits each: performance counters.

Function
REQ-013 SHALL implement states RUN, LD_STALL and DIV_WAIT, held in a registered state variable.
REQ-014 In RUN with hzd_mem_to_exe_A or hzd_mem_to_exe_B set, SHALL assert if_stall, id_stall and exe_stall plus mem_flush in the same cycle, then go to LD_STALL.
REQ-015 In RUN with only hzd_exe_to_id_A set, SHALL assert if_stall and id_stall plus exe_flush in the same cycle, then go to LD_STALL.
REQ-016 In LD_STALL, SHALL ignore all hazard inputs, assert no stall, and return to RUN after exactly 1 cycle, so each load-use stall lasts exactly 1 cycle.
REQ-017 In RUN with exe_div_start set and div_done clear, SHALL go to DIV_WAIT.
REQ-018 In DIV_WAIT, SHALL assert if_stall, id_stall and exe_stall plus mem_flush every cycle.
REQ-019 In DIV_WAIT, the cycle div_done is set SHALL deassert all stalls and return to RUN; exe_div_start together with div_done in RUN SHALL cause no stall.
REQ-020 In DIV_WAIT, SHALL count cycles in a saturating counter and set div_timeout when the count reaches DIV_TIMEOUT; div_timeout SHALL stay set until rst and SHALL NOT force an exit from DIV_WAIT.
REQ-021 With exe_branch_taken set and exe_stall clear, SHALL assert id_flush and exe_flush.
REQ-022 With exe_branch_taken set and exe_stall set, SHALL suppress the flush; the branch stays in EXE and flushes on its first unstalled cycle.
REQ-023 With id_jump set and id_stall clear, SHALL assert id_flush only; while id_stall is set, the jump flush SHALL be deferred.
REQ-024 SHALL give exe_branch_taken priority over id_jump; when both are set, id_flush and exe_flush SHALL be asserted once.
REQ-025 SHALL apply stall priority in this order: DIV_WAIT, then hzd_mem_to_exe_*, then hzd_exe_to_id_A.
REQ-026 Simultaneous mem_to_exe and exe_to_id hazards SHALL produce the REQ-014 response only.
REQ-027 SHALL hold mem_stall at 0 and wb_flush at 0 outside reset; both ports exist for future multi-cycle data-memory use.
REQ-028 SHALL compute all stall and flush outputs combinationally from the current state and inputs, with 0-cycle latency.
REQ-029 SHALL increment stall_count once per cycle in which if_stall is set.
REQ-030 SHALL increment flush_count once per cycle in which id_flush or exe_flush is set.
REQ-031 Both counters SHALL wrap modulo 2^STALL_CNT_BITS.

Reset
REQ-032 On a clk edge with rst set, SHALL set the state to RUN and clear stall_count, flush_count, the DIV_WAIT counter and div_timeout.
REQ-033 While rst is set, SHALL drive all *_flush outputs to 1 and all *_stall outputs to 0.
REQ-034 Reset asserted in LD_STALL or DIV_WAIT SHALL abandon the stall, and RUN behaviour SHALL resume on the first cycle after rst deasserts.

Structure
REQ-035 SHALL place the state encoding (RUN=2'd0, LD_STALL=2'd1, DIV_WAIT=2'd2) and the DIV_TIMEOUT default in the shared constants header.
REQ-036 SHALL contain one sub-module, perf_counter, instantiated twice for stall_count and flush_count, with inputs clk, rst and inc and output count.

Verification
REQ-037 Bench SHALL drive hzd_mem_to_exe_B=1 for 2 cycles from RUN and check if/id/exe_stall=1 and mem_flush=1 in cycle 1 only, with stall_count=1.
REQ-038 Bench SHALL drive hzd_exe_to_id_A=1 for 1 cycle and check if_stall=id_stall=1, exe_flush=1 and exe_stall=0.
REQ-039 Bench SHALL drive exe_div_start=1 with div_done rising 5 cycles later and check stalls asserted for exactly 5 cycles, a return to RUN, and stall_count=5.
REQ-040 Bench SHALL hold div_done=0 for 70 cycles after exe_div_start with DIV_TIMEOUT=64 and check div_timeout=1 from cycle 64 onward, with stalls still asserted.
REQ-041 Bench SHALL drive exe_branch_taken=1 during DIV_WAIT and check no flush until div_done, then id_flush=exe_flush=1 for exactly 1 cycle.
REQ-042 Bench SHALL assert rst during DIV_WAIT and check all flushes=1, all stalls=0, counters=0 and div_timeout=0 on the next cycle.

Source files
------------

// File: rtl/hazard_controller_pkg.sv
// ---------------------------------------------------------------------------
// hazard_controller_pkg
// Shared constants for the pipeline hazard controller: the controller state
// encoding and the default parameter values used by the top level.
// ---------------------------------------------------------------------------
package hazard_controller_pkg;

    // Controller states. The encoding is fixed so that external observers
    // (debug taps, formal properties) can rely on it.
    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LD_STALL = 2'd1,
        DIV_WAIT = 2'd2
    } hc_state_e;

    // Default number of DIV_WAIT cycles before div_timeout is raised.
    localparam int DIV_TIMEOUT_DEFAULT    = 64;

    // Default width of the stall/flush performance counters.
    localparam int STALL_CNT_BITS_DEFAULT = 32;

endpackage : hazard_controller_pkg

// File: rtl/hazard_controller_if.sv
// ---------------------------------------------------------------------------
// hazard_controller_if
// Bundle of the pipeline-facing hazard signals.
//   Hazard requests (pipeline -> controller):
//     hzd_exe_to_id_A, hzd_mem_to_exe_A, hzd_mem_to_exe_B : load-use hazards
//     id_jump          : JAL/JALR in ID redirects the PC
//     exe_branch_taken : branch in EXE resolved taken
//     exe_div_start    : divide/remainder starts in EXE
//     div_done         : divider result valid
//   Pipeline control (controller -> pipeline):
//     if_stall, id_stall, exe_stall, mem_stall : hold PC / pipeline registers
//     id_flush, exe_flush, mem_flush, wb_flush : insert bubbles
// Modports: master = pipeline side, slave = hazard controller.
// ---------------------------------------------------------------------------
interface hazard_controller_if;

    logic hzd_exe_to_id_A;
    logic hzd_mem_to_exe_A;
    logic hzd_mem_to_exe_B;
    logic id_jump;
    logic exe_branch_taken;
    logic exe_div_start;
    logic div_done;

    logic if_stall;
    logic id_stall;
    logic exe_stall;
    logic mem_stall;
    logic id_flush;
    logic exe_flush;
    logic mem_flush;
    logic wb_flush;

    modport master (
        output hzd_exe_to_id_A, hzd_mem_to_exe_A, hzd_mem_to_exe_B,
        output id_jump, exe_branch_taken, exe_div_start, div_done,
        input  if_stall, id_stall, exe_stall, mem_stall,
        input  id_flush, exe_flush, mem_flush, wb_flush
    );

    modport slave (
        input  hzd_exe_to_id_A, hzd_mem_to_exe_A, hzd_mem_to_exe_B,
        input  id_jump, exe_branch_taken, exe_div_start, div_done,
        output if_stall, id_stall, exe_stall, mem_stall,
        output id_flush, exe_flush, mem_flush, wb_flush
    );

endinterface : hazard_controller_if

// File: rtl/hazard_controller_perf_counter.sv
// ---------------------------------------------------------------------------
// perf_counter
// Free-running event counter that wraps modulo 2^WIDTH.
// Ports:
//   clk   : clock
//   rst   : synchronous active-high reset, clears the count
//   inc   : count one event this cycle
//   count : current count
// ---------------------------------------------------------------------------
module perf_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // Natural binary overflow gives the required wrap-around.
    always_comb begin
        count_d = count_q;
        if (inc) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule : perf_counter

// File: rtl/hazard_controller.sv
// ---------------------------------------------------------------------------
// hazard_controller
// Stall/flush controller for a 5-stage pipeline: load-use stalls, multi-cycle
// divide waits, and branch/jump redirect flushes.
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   hif (slave)  : hazard requests in, stall/flush controls out
//   div_timeout  : sticky, divider stayed in DIV_WAIT for DIV_TIMEOUT cycles
//   stall_count  : cycles with if_stall set (wraps)
//   flush_count  : cycles with id_flush or exe_flush set (wraps)
// All stall/flush outputs are combinational from state and inputs.
// ---------------------------------------------------------------------------
module hazard_controller
    import hazard_controller_pkg::*;
#(
    parameter int STALL_CNT_BITS = STALL_CNT_BITS_DEFAULT,
    parameter int DIV_TIMEOUT    = DIV_TIMEOUT_DEFAULT
) (
    input  logic                      clk,
    input  logic                      rst,
    hazard_controller_if.slave        hif,
    output logic                      div_timeout,
    output logic [STALL_CNT_BITS-1:0] stall_count,
    output logic [STALL_CNT_BITS-1:0] flush_count
);

    localparam int                   DIV_CNT_W = $clog2(DIV_TIMEOUT + 1);
    localparam logic [DIV_CNT_W-1:0] DIV_LIMIT = DIV_CNT_W'(DIV_TIMEOUT);

    hc_state_e            state_q;
    hc_state_e            state_d;
    logic [DIV_CNT_W-1:0] div_cnt_q;
    logic [DIV_CNT_W-1:0] div_cnt_d;
    logic                 div_timeout_q;
    logic                 div_timeout_d;

    logic if_stall;
    logic id_stall;
    logic exe_stall;
    logic id_flush;
    logic exe_flush;
    logic mem_flush;
    logic wb_flush;

    // ------------------------------------------------------------------
    // Next state and stall/flush decode
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        if_stall  = 1'b0;
        id_stall  = 1'b0;
        exe_stall = 1'b0;
        id_flush  = 1'b0;
        exe_flush = 1'b0;
        mem_flush = 1'b0;
        wb_flush  = 1'b0;

        if (rst) begin
            // Bubble every stage while in reset; nothing is held.
            id_flush  = 1'b1;
            exe_flush = 1'b1;
            mem_flush = 1'b1;
            wb_flush  = 1'b1;
            state_d   = RUN;
        end else begin
            case (state_q)
                RUN: begin
                    if (hif.hzd_mem_to_exe_A || hif.hzd_mem_to_exe_B) begin
                        // Consumer in EXE: hold IF..EXE, bubble into MEM.
                        if_stall  = 1'b1;
                        id_stall  = 1'b1;
                        exe_stall = 1'b1;
                        mem_flush = 1'b1;
                        state_d   = LD_STALL;
                    end else if (hif.hzd_exe_to_id_A) begin
                        // Consumer in ID: hold IF/ID, bubble into EXE.
                        if_stall  = 1'b1;
                        id_stall  = 1'b1;
                        exe_flush = 1'b1;
                        state_d   = LD_STALL;
                    end else if (hif.exe_div_start && !hif.div_done) begin
                        state_d = DIV_WAIT;
                    end
                end
                LD_STALL: begin
                    // The load has now reached the forwarding point, so the
                    // hazard flags are stale for one cycle and are ignored.
                    state_d = RUN;
                end
                DIV_WAIT: begin
                    if (hif.div_done) begin
                        state_d = RUN;
                    end else begin
                        if_stall  = 1'b1;
                        id_stall  = 1'b1;
                        exe_stall = 1'b1;
                        mem_flush = 1'b1;
                    end
                end
                default: begin
                    state_d = RUN;
                end
            endcase

            // Redirect flushes. A stalled branch stays in EXE with its flag
            // still raised, so the flush happens on its first free cycle.
            // A taken branch also covers any jump in ID.
            if (hif.exe_branch_taken) begin
                if (!exe_stall) begin
                    id_flush  = 1'b1;
                    exe_flush = 1'b1;
                end
            end else if (hif.id_jump && !id_stall) begin
                id_flush = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Divide watchdog: counts DIV_WAIT cycles including the current one,
    // saturating at DIV_LIMIT. The flag only reports; it never forces an
    // exit from DIV_WAIT.
    // ------------------------------------------------------------------
    always_comb begin
        div_cnt_d     = '0;
        div_timeout_d = div_timeout_q;
        if (state_d == DIV_WAIT) begin
            div_cnt_d = div_cnt_q;
            if (div_cnt_q != DIV_LIMIT) begin
                div_cnt_d = div_cnt_q + 1'b1;
            end
        end
        if (div_cnt_d == DIV_LIMIT) begin
            div_timeout_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= RUN;
            div_cnt_q     <= '0;
            div_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            div_cnt_q     <= div_cnt_d;
            div_timeout_q <= div_timeout_d;
        end
    end

    // ------------------------------------------------------------------
    // Performance counters: index 0 = stall cycles, 1 = flush cycles.
    // ------------------------------------------------------------------
    logic [1:0]                cnt_inc;
    logic [STALL_CNT_BITS-1:0] cnt_val [2];

    assign cnt_inc[0] = if_stall;
    assign cnt_inc[1] = id_flush | exe_flush;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_perf
            perf_counter #(
                .WIDTH (STALL_CNT_BITS)
            ) u_perf_counter (
                .clk   (clk),
                .rst   (rst),
                .inc   (cnt_inc[gi]),
                .count (cnt_val[gi])
            );
        end
    endgenerate

    assign stall_count = cnt_val[0];
    assign flush_count = cnt_val[1];
    assign div_timeout = div_timeout_q;

    // Outputs to the pipeline. mem_stall is reserved for a future
    // multi-cycle data memory and is never raised today.
    assign hif.if_stall  = if_stall;
    assign hif.id_stall  = id_stall;
    assign hif.exe_stall = exe_stall;
    assign hif.mem_stall = 1'b0;
    assign hif.id_flush  = id_flush;
    assign hif.exe_flush = exe_flush;
    assign hif.mem_flush = mem_flush;
    assign hif.wb_flush  = wb_flush;

endmodule : hazard_controller

// File: tb/tb_hazard_controller.sv
// ---------------------------------------------------------------------------
// tb_hazard_controller
// Directed bench for hazard_controller. Stalls are compared as
// {if,id,exe,mem} and flushes as {id,exe,mem,wb}.
// ---------------------------------------------------------------------------
module tb_hazard_controller;

    logic        clk;
    logic        rst;
    logic        div_timeout;
    logic [31:0] stall_count;
    logic [31:0] flush_count;

    int n_vec;
    int n_err;

    hazard_controller_if hif ();

    hazard_controller #(
        .STALL_CNT_BITS (32),
        .DIV_TIMEOUT    (64)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .hif         (hif.slave),
        .div_timeout (div_timeout),
        .stall_count (stall_count),
        .flush_count (flush_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [3:0] stl;
    logic [3:0] fls;
    assign stl = {hif.if_stall, hif.id_stall, hif.exe_stall, hif.mem_stall};
    assign fls = {hif.id_flush, hif.exe_flush, hif.mem_flush, hif.wb_flush};

    task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_vec++;
        assert (observed === expected) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
        $display("vec %0d %s: observed %0h expected %0h", n_vec, tag, observed, expected);
    endtask

    task automatic out(input string tag, input logic [3:0] st, input logic [3:0] fl);
        chk({tag, " stalls"}, {28'd0, stl}, {28'd0, st});
        chk({tag, " flushes"}, {28'd0, fls}, {28'd0, fl});
    endtask

    task automatic cnts(input string tag, input logic [31:0] sc, input logic [31:0] fc);
        chk({tag, " stall_count"}, stall_count, sc);
        chk({tag, " flush_count"}, flush_count, fc);
    endtask

    // Advance to just after the next active edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst   = 1'b1;
        hif.hzd_exe_to_id_A  = 1'b0;
        hif.hzd_mem_to_exe_A = 1'b0;
        hif.hzd_mem_to_exe_B = 1'b0;
        hif.id_jump          = 1'b0;
        hif.exe_branch_taken = 1'b0;
        hif.exe_div_start    = 1'b0;
        hif.div_done         = 1'b0;

        // Reset state
        tick();
        tick();
        #1;
        out("reset", 4'b0000, 4'b1111);
        cnts("reset", 32'd0, 32'd0);
        chk("reset div_timeout", {31'd0, div_timeout}, 32'd0);
        rst = 1'b0;
        #1;
        out("idle", 4'b0000, 4'b0000);

        // mem_to_exe_B held 2 cycles: stall in the first cycle only
        tick();
        hif.hzd_mem_to_exe_B = 1'b1;
        #1;
        out("mexeB c1", 4'b1110, 4'b0010);
        tick();
        #1;
        out("mexeB c2", 4'b0000, 4'b0000);
        chk("mexeB stall_count", stall_count, 32'd1);
        hif.hzd_mem_to_exe_B = 1'b0;
        tick();
        #1;
        cnts("mexeB done", 32'd1, 32'd0);

        // exe_to_id_A: IF/ID held, EXE bubbled, EXE not stalled
        hif.hzd_exe_to_id_A = 1'b1;
        #1;
        out("exeid", 4'b1100, 4'b0100);
        tick();
        hif.hzd_exe_to_id_A  = 1'b0;
        hif.hzd_mem_to_exe_A = 1'b1;
        #1;
        out("ld_stall ignores hazard", 4'b0000, 4'b0000);
        cnts("exeid", 32'd2, 32'd1);
        hif.hzd_mem_to_exe_A = 1'b0;
        tick();

        // Both load-use hazards: mem_to_exe response only
        hif.hzd_mem_to_exe_A = 1'b1;
        hif.hzd_exe_to_id_A  = 1'b1;
        #1;
        out("both hazards", 4'b1110, 4'b0010);
        tick();
        hif.hzd_mem_to_exe_A = 1'b0;
        hif.hzd_exe_to_id_A  = 1'b0;
        #1;
        cnts("both hazards", 32'd3, 32'd1);
        tick();

        // Divide with 5 wait cycles
        hif.exe_div_start = 1'b1;
        #1;
        out("div start", 4'b0000, 4'b0000);
        tick();
        hif.exe_div_start = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            #1;
            out("div wait", 4'b1110, 4'b0010);
            tick();
        end
        hif.div_done = 1'b1;
        #1;
        out("div done", 4'b0000, 4'b0000);
        tick();
        hif.div_done = 1'b0;
        #1;
        chk("div stall_count", stall_count, 32'd8);
        hif.hzd_exe_to_id_A = 1'b1;
        #1;
        out("div back in run", 4'b1100, 4'b0100);
        tick();
        hif.hzd_exe_to_id_A = 1'b0;
        #1;
        cnts("after div", 32'd9, 32'd2);
        tick();

        // Divide start together with div_done: no stall at all
        hif.exe_div_start = 1'b1;
        hif.div_done      = 1'b1;
        #1;
        out("start+done", 4'b0000, 4'b0000);
        tick();
        hif.exe_div_start = 1'b0;
        hif.div_done      = 1'b0;
        #1;
        out("no div wait", 4'b0000, 4'b0000);

        // Taken branch during DIV_WAIT flushes once, after div_done
        hif.exe_div_start = 1'b1;
        tick();
        hif.exe_div_start    = 1'b0;
        hif.exe_branch_taken = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            #1;
            out("branch in div", 4'b1110, 4'b0010);
            tick();
        end
        hif.div_done = 1'b1;
        #1;
        out("branch release", 4'b0000, 4'b1100);
        tick();
        hif.div_done         = 1'b0;
        hif.exe_branch_taken = 1'b0;
        #1;
        out("branch once", 4'b0000, 4'b0000);
        cnts("branch", 32'd12, 32'd3);

        // Jumps: plain, with branch, deferred by a stall
        hif.id_jump = 1'b1;
        #1;
        out("jump", 4'b0000, 4'b1000);
        tick();
        hif.exe_branch_taken = 1'b1;
        #1;
        out("jump+branch", 4'b0000, 4'b1100);
        tick();
        hif.exe_branch_taken = 1'b0;
        hif.hzd_exe_to_id_A  = 1'b1;
        #1;
        out("jump stalled", 4'b1100, 4'b0100);
        tick();
        hif.hzd_exe_to_id_A = 1'b0;
        #1;
        out("jump deferred", 4'b0000, 4'b1000);
        tick();
        hif.id_jump = 1'b0;
        #1;
        cnts("jump", 32'd13, 32'd7);

        // Divide timeout: 70 wait cycles, flag from cycle 64, no forced exit
        hif.exe_div_start = 1'b1;
        tick();
        hif.exe_div_start = 1'b0;
        for (int n = 1; n <= 70; n++) begin
            #1;
            out("div long", 4'b1110, 4'b0010);
            chk("div_timeout", {31'd0, div_timeout}, (n >= 64) ? 32'd1 : 32'd0);
            tick();
        end
        hif.div_done = 1'b1;
        #1;
        out("long release", 4'b0000, 4'b0000);
        tick();
        hif.div_done = 1'b0;
        #1;
        chk("div_timeout sticky", {31'd0, div_timeout}, 32'd1);
        chk("long stall_count", stall_count, 32'd83);

        // Reset during DIV_WAIT
        hif.exe_div_start = 1'b1;
        tick();
        hif.exe_div_start = 1'b0;
        #1;
        out("pre reset", 4'b1110, 4'b0010);
        rst = 1'b1;
        #1;
        out("reset in div", 4'b0000, 4'b1111);
        tick();
        #1;
        out("reset held", 4'b0000, 4'b1111);
        cnts("reset held", 32'd0, 32'd0);
        chk("reset div_timeout clr", {31'd0, div_timeout}, 32'd0);
        rst = 1'b0;
        #1;
        out("post reset", 4'b0000, 4'b0000);
        hif.hzd_mem_to_exe_A = 1'b1;
        #1;
        out("post reset hazard", 4'b1110, 4'b0010);
        tick();
        hif.hzd_mem_to_exe_A = 1'b0;
        #1;
        cnts("post reset", 32'd1, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_hazard_controller
